da_bit_slicer: RTL and testbench

//   Sample delay line and bit-slice serializer feeding the distributed-arithmetic (DA) engine of the FIR filter.
//   - Holds the last TAPS input samples.
//   - After each new sample, presents one bit-slice per beat: bit b of every tap, LSB first, sign bit last.
//   - The DA engine uses each slice as its LUT address.
//   - Sits between the filter control FSM (drives enable/clear_n) and the DA accumulator.

---
 rtl/da_bit_slicer.sv | 137 +++++++++++++
 tb/tb_da_bit_slicer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/da_bit_slicer.sv
// rtl/da_bit_slicer.sv - sample delay line and bit-slice serializer for the DA FIR engine
//
// Purpose:
//    Keeps the last TAPS samples. Each accepted sample starts a burst of WIDTH
//    bit-slices, LSB first and sign bit last. Every slice is one bit from every tap.
//    The DA engine uses each slice as its LUT address.
//
// Ports:
//    clk           rising-edge clock
//    resetn        asynchronous active-low reset
//    enable        run enable; low freezes all state and masks both handshakes
//    clear_n       synchronous active-low clear; priority over everything but resetn
//    sample_valid  input sample offered
//    sample_in     input sample, two's complement, WIDTH bits
//    sample_ready  slicer accepts a sample this cycle (IDLE only)
//    slice_valid   slice_out holds a valid bit-slice (SLICE only)
//    slice_ready   DA engine accepts the current slice
//    slice_out     slice_out[k] = tap[k][bit_cnt]; tap[0] is the newest sample
//    slice_last    current slice is the sign bit
//    taps_full     TAPS samples loaded since the last clear/reset
module da_bit_slicer #(
   parameter int TAPS  = 8,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic             clear_n,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample_in,
   output logic             sample_ready,
   output logic             slice_valid,
   input  logic             slice_ready,
   output logic [TAPS-1:0]  slice_out,
   output logic             slice_last,
   output logic             taps_full
);

   localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int FILL_W = $clog2(TAPS + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(TAPS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SLICE = 2'b01
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_taps [TAPS];
   logic [CNT_W-1:0]   r_bit_cnt;
   logic [FILL_W-1:0]  r_fill_cnt;
   logic               w_accept;
   logic               w_advance;
   logic               w_done;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else if (!clear_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // sample_ready is also masked by resetn so that it reads 0 while reset is held.
   // An unused state encoding falls to the default branch and returns to IDLE.
   always_comb begin
      w_next_state = r_state;
      sample_ready = 1'b0;
      slice_valid  = 1'b0;
      w_accept     = 1'b0;
      w_advance    = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            sample_ready = enable & resetn;
            w_accept     = sample_ready & sample_valid;
            if (w_accept) begin
               w_next_state = S_SLICE;
            end
         end
         S_SLICE: begin
            slice_valid = enable;
            w_advance   = slice_valid & slice_ready;
            w_done      = w_advance && (r_bit_cnt == LAST_BIT);
            if (w_done) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < TAPS; k++) begin
            r_taps[k] <= '0;
         end
         r_bit_cnt  <= '0;
         r_fill_cnt <= '0;
      end else if (!clear_n) begin
         for (int k = 0; k < TAPS; k++) begin
            r_taps[k] <= '0;
         end
         r_bit_cnt  <= '0;
         r_fill_cnt <= '0;
      end else if (w_accept) begin
         for (int k = TAPS - 1; k > 0; k--) begin
            r_taps[k] <= r_taps[k-1];
         end
         r_taps[0] <= sample_in;
         r_bit_cnt <= '0;
         if (r_fill_cnt != FULL_CNT) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
         end
      end else if (w_advance) begin
         // bit_cnt returns to 0 after the sign beat, so slice_last stays low in IDLE.
         r_bit_cnt <= w_done ? '0 : r_bit_cnt + 1'b1;
      end
   end

   always_comb begin
      slice_out = '0;
      for (int k = 0; k < TAPS; k++) begin
         slice_out[k] = r_taps[k][r_bit_cnt];
      end
   end

   assign slice_last = (r_bit_cnt == LAST_BIT);
   assign taps_full  = (r_fill_cnt == FULL_CNT);

endmodule

// File: tb/tb_da_bit_slicer.sv
// tb/tb_da_bit_slicer.sv - self-checking bench for da_bit_slicer (TAPS=4, WIDTH=4)
module tb_da_bit_slicer;

   localparam int TAPS  = 4;
   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             resetn;
   logic             enable;
   logic             clear_n;
   logic             sample_valid;
   logic [WIDTH-1:0] sample_in;
   logic             sample_ready;
   logic             slice_valid;
   logic             slice_ready;
   logic [TAPS-1:0]  slice_out;
   logic             slice_last;
   logic             taps_full;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the delay line as a plain array, plus "busy" and the beat index.
   int m_taps [TAPS];
   int m_fill;
   bit m_busy;
   int m_bit;

   da_bit_slicer #(.TAPS(TAPS), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .enable       (enable),
      .clear_n      (clear_n),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .sample_ready (sample_ready),
      .slice_valid  (slice_valid),
      .slice_ready  (slice_ready),
      .slice_out    (slice_out),
      .slice_last   (slice_last),
      .taps_full    (taps_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic m_reset();
      for (int k = 0; k < TAPS; k++) m_taps[k] = 0;
      m_fill = 0;
      m_busy = 1'b0;
      m_bit  = 0;
   endtask

   function automatic logic [TAPS-1:0] exp_slice(input int b);
      logic [TAPS-1:0] s;
      for (int k = 0; k < TAPS; k++) s[k] = ((m_taps[k] >> b) & 1) != 0;
      return s;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".sample_ready"}, 32'(sample_ready), 32'(enable && !m_busy));
      check({tag, ".slice_valid"},  32'(slice_valid),  32'(enable && m_busy));
      check({tag, ".taps_full"},    32'(taps_full),    32'(m_fill == TAPS));
      if (m_busy) begin
         check({tag, ".slice_out"},  32'(slice_out),  32'(exp_slice(m_bit)));
         check({tag, ".slice_last"}, 32'(slice_last), 32'(m_bit == WIDTH - 1));
      end
   endtask

   // Advance the model by one clock using the inputs as they stand, clock the DUT,
   // then compare just after the edge.
   task automatic tick(input string tag);
      if (!clear_n) begin
         m_reset();
      end else if (enable) begin
         if (!m_busy && sample_valid) begin
            for (int k = TAPS - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
            m_taps[0] = int'(sample_in);
            m_fill = (m_fill < TAPS) ? m_fill + 1 : TAPS;
            m_busy = 1'b1;
            m_bit  = 0;
         end else if (m_busy && slice_ready) begin
            if (m_bit == WIDTH - 1) m_busy = 1'b0;
            else m_bit++;
         end
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic send(input logic [WIDTH-1:0] s, input string tag);
      sample_in    = s;
      sample_valid = 1'b1;
      tick(tag);
      sample_valid = 1'b0;
   endtask

   initial begin
      resetn       = 1'b0;
      enable       = 1'b1;
      clear_n      = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      slice_ready  = 1'b1;
      m_reset();

      // Reset state
      #12;
      check("rst.sample_ready", 32'(sample_ready), 32'd0);
      check("rst.slice_valid",  32'(slice_valid),  32'd0);
      check("rst.slice_out",    32'(slice_out),    32'd0);
      check("rst.slice_last",   32'(slice_last),   32'd0);
      check("rst.taps_full",    32'(taps_full),    32'd0);
      resetn = 1'b1;
      #1;
      check("rst.release_ready", 32'(sample_ready), 32'd1);

      // 1: async reset pulse mid-SLICE
      send(4'hA, "t1.accept");
      tick("t1.slice");
      tick("t1.slice");
      #2;
      resetn = 1'b0;
      #1;
      check("t1.async.sample_ready", 32'(sample_ready), 32'd0);
      check("t1.async.slice_valid",  32'(slice_valid),  32'd0);
      check("t1.async.slice_out",    32'(slice_out),    32'd0);
      check("t1.async.slice_last",   32'(slice_last),   32'd0);
      check("t1.async.taps_full",    32'(taps_full),    32'd0);
      resetn = 1'b1;
      m_reset();
      #1;
      check("t1.release_ready", 32'(sample_ready), 32'd1);

      // 2: clear, then 4'h5 with slice_ready high
      clear_n = 1'b0;
      tick("t2.clear");
      clear_n = 1'b1;
      send(4'h5, "t2.accept");
      check("t2.slice0", 32'(slice_out), 32'b0001);
      tick("t2.b1");
      check("t2.slice1", 32'(slice_out), 32'b0000);
      tick("t2.b2");
      check("t2.slice2", 32'(slice_out), 32'b0001);
      tick("t2.b3");
      check("t2.slice3", 32'(slice_out), 32'b0000);
      check("t2.last",   32'(slice_last), 32'd1);
      tick("t2.idle");
      check("t2.ready_back", 32'(sample_ready), 32'd1);

      // 3: fill the delay line
      clear_n = 1'b0;
      tick("t3.clear");
      clear_n = 1'b1;
      send(4'h1, "t3.s1"); repeat (4) tick("t3.run");
      send(4'h2, "t3.s2"); repeat (4) tick("t3.run");
      send(4'h3, "t3.s3"); repeat (4) tick("t3.run");
      check("t3.not_full", 32'(taps_full), 32'd0);
      send(4'hF, "t3.s4");
      check("t3.full", 32'(taps_full), 32'd1);
      repeat (4) tick("t3.run4");

      // 4: stall at bit 2
      send(4'h9, "t4.accept");
      repeat (2) tick("t4.run");
      slice_ready = 1'b0;
      repeat (3) tick("t4.stall");
      slice_ready = 1'b1;
      repeat (2) tick("t4.resume");

      // 5: enable drop mid-SLICE with sample_valid pressing
      send(4'h6, "t5.accept");
      tick("t5.run");
      enable       = 1'b0;
      sample_valid = 1'b1;
      sample_in    = 4'hC;
      repeat (2) tick("t5.drop");
      enable = 1'b1;
      repeat (3) tick("t5.resume");
      sample_valid = 1'b0;

      // 6: clear during SLICE with sample_valid high
      send(4'h7, "t6.accept");
      tick("t6.run");
      sample_valid = 1'b1;
      clear_n      = 1'b0;
      tick("t6.clear");
      clear_n      = 1'b0;
      check("t6.taps_full", 32'(taps_full), 32'd0);
      clear_n      = 1'b1;
      sample_valid = 1'b0;
      tick("t6.after");

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         enable       = ($urandom_range(9) != 0);
         slice_ready  = ($urandom_range(9) < 7);
         sample_valid = $urandom_range(1);
         clear_n      = ($urandom_range(49) != 0);
         sample_in    = WIDTH'($urandom);
         tick("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
